ahblite_block_ram: RTL and testbench
====================================

# ahblite_block_ram

- AHB-Lite slave bridging a 32-bit bus to a single-port synchronous block RAM with byte-lane write enables.
- Successor to the read-only block-ROM interface: adds buffered zero-wait writes, read-after-write forwarding and a one-cycle hazard stall.
- Sits on the system AHB-Lite matrix as on-chip code/data memory.
- Reads are zero-wait. Writes complete zero-wait into a one-entry write buffer that drains to the BRAM on the next free port cycle.

## Interface
Parameters:
- ADDR_WIDTH, 13: BRAM word-address width; the byte window is 2^(ADDR_WIDTH+2) bytes.

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ/SEQ.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HPROT  in  4  ignored.
- HWRITE  in  1  1=write.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  2  2'b00 OKAY, 2'b01 ERROR.
- BRAM_ADDR  out  ADDR_WIDTH  BRAM word address.
- BRAM_RDATA  in  32  BRAM read data; valid one cycle after address.
- BRAM_WDATA  out  32  BRAM write data.
- BRAM_WE  out  4  byte write enables; bit n = HWDATA[8n+7:8n].

## Operation
- Accept = HSEL & HREADY & HTRANS[1]. IDLE/BUSY and unselected cycles get OKAY, zero-wait.
- Strobe from HSIZE/HADDR[1:0]:
  - byte: 4'b0001<<HADDR[1:0]
  - half: HADDR[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Misalignment is not checked.
- Address phase registers, cleared at reset: rd_dphase, wr_dphase, word address, strobe.
- Write buffer: buf_valid, buf_addr, buf_strb, buf_data.
  - Loaded at the end of every completed write data phase (HREADYOUT=1), with buf_data=HWDATA.
- Drain: whenever no read is accepted this cycle and buf_valid=1:
  - BRAM_WE=buf_strb, BRAM_ADDR=buf_addr, BRAM_WDATA=buf_data.
  - buf_valid clears, unless the buffer reloads at the same edge.
- Otherwise BRAM_ADDR=HADDR[ADDR_WIDTH+1:2] and BRAM_WE=0.
- Hazard stall: wr_dphase & buf_valid & read request (HSEL & HTRANS[1] & !HWRITE).
  - HREADYOUT=0 for one cycle; the read is not accepted and the old buffer drains.
  - Next cycle: HREADYOUT=1, the read is accepted and the new write loads the buffer.
- Forwarding: in a read data phase with buf_valid and buf_addr == data-phase address, each HRDATA byte lane set in buf_strb comes from buf_data; the other lanes come from BRAM_RDATA.
  - Otherwise HRDATA=BRAM_RDATA (combinational).
- Reset mid-operation: pending buffered write is discarded; nothing is written to the BRAM.

## Timing
- Reset values: HREADYOUT=1, HRESP=2'b00, BRAM_WE=4'b0000, buf_valid=0, rd_dphase=0, wr_dphase=0.
- Read: address phase at cycle N, HRDATA valid at N+1, zero wait.
- Write: address at N, data at N+1. BRAM write occurs at the earliest cycle ≥N+2 without an accepted read.
- Back-to-back writes (W,W,W): zero wait; each buffer entry drains in the cycle the next one loads.
- Sequence W,W,R: one stall cycle during the second write's data phase.
- HRESP nonzero only under the configured error feature.

## Configuration
- AHB_BRAM_RO_ERR_EN defined: writes are rejected, so the block behaves as ROM.
  - Accepted write gets a two-cycle ERROR: cycle 1 HREADYOUT=0, HRESP=01; cycle 2 HREADYOUT=1, HRESP=01.
  - No buffer load and BRAM_WE never asserts.
  - A transfer presented during cycle 2 is accepted normally.
- Undefined: writes are performed as above and HRESP is tied to 2'b00.

## Test plan
- Reset assertion mid-write (buffer valid) → all outputs at reset values immediately; after release, reading that address returns the old BRAM value, not the write data.
- Word write 0xDEADBEEF @0x10, then idle cycles → BRAM_WE=1111, BRAM_ADDR=4, BRAM_WDATA=0xDEADBEEF for exactly one cycle; later read @0x10 returns 0xDEADBEEF.
- BRAM holds 0x11223344 @0x20; byte write 0xAA to 0x21, then read 0x20 back-to-back → zero wait; HRDATA=0x1122AA44 (lane 1 forwarded).
- Half write @0x42 then read @0x40 → strobe 1100; upper lanes forwarded.
- Sequence W@0x0, W@0x4, R@0x8 → exactly one HREADYOUT=0 cycle in the W@0x4 data phase; both writes land; read correct.
- With AHB_BRAM_RO_ERR_EN: write @0x0 → HRESP=01 for two cycles, HREADYOUT 0 then 1; BRAM_WE stays 0; next read OKAY.

Source files
------------

// File: rtl/ahblite_block_ram_if.sv
// AHB-Lite bus bundle for the block-RAM slave.
// The master modport is the matrix/testbench side; the slave modport is the memory side.
interface ahblite_block_ram_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_block_ram.sv
// AHB-Lite slave in front of a single-port synchronous block RAM.
// Reads are zero-wait. Writes land in a one-entry buffer that drains on the next
// cycle the RAM port is not claimed by an accepted read. A read that arrives while
// a write is in its data phase and the buffer is still full stalls one cycle so
// the old entry can drain. Reads of a buffered word are forwarded lane by lane.
//
// Build option AHB_BRAM_RO_ERR_EN: writes are refused with a two-cycle ERROR
// response, making the block a ROM.
//   state      | meaning
//   ERR_IDLE   | no error response in progress
//   ERR_FIRST  | first ERROR cycle, HREADYOUT low
//   ERR_SECOND | second ERROR cycle, HREADYOUT high, next transfer may be accepted
module ahblite_block_ram #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahblite_block_ram_if.slave    ahb,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    input  logic [31:0]           BRAM_RDATA,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE
);
    logic                  accept, rd_req, rd_accept, wr_accept;
    logic                  stall, hready_out, buf_load, drain, fwd_hit;
    logic                  err_ready;
    logic [1:0]            err_resp;
    logic [3:0]            strb;
    logic [31:0]           rdata;
    logic [ADDR_WIDTH-1:0] haddr_word;

    logic                  rd_dphase_q, rd_dphase_d;
    logic                  wr_dphase_q, wr_dphase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            strb_q, strb_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]            buf_strb_q, buf_strb_d;
    logic [31:0]           buf_data_q, buf_data_d;

    logic                  unused_bits;
    assign unused_bits = ^{ahb.HPROT, ahb.HSIZE[2], ahb.HADDR[31:ADDR_WIDTH+2]};

    assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
    assign accept     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    // Read request deliberately ignores HREADY: it is what raises the stall.
    assign rd_req     = ahb.HSEL & ahb.HTRANS[1] & ~ahb.HWRITE;
    assign rd_accept  = accept & ~ahb.HWRITE;

`ifdef AHB_BRAM_RO_ERR_EN
    typedef enum logic [1:0] {ERR_IDLE, ERR_FIRST, ERR_SECOND} err_state_e;
    err_state_e err_state_q, err_state_d;

    assign wr_accept = 1'b0;

    // Error-response state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) err_state_q <= ERR_IDLE;
        else        err_state_q <= err_state_d;
    end

    // Error-response sequencing and its bus outputs.
    always_comb begin
        err_state_d = err_state_q;
        err_ready   = 1'b1;
        err_resp    = 2'b00;
        case (err_state_q)
            ERR_IDLE: begin
                if (accept && ahb.HWRITE) err_state_d = ERR_FIRST;
            end
            ERR_FIRST: begin
                err_ready   = 1'b0;
                err_resp    = 2'b01;
                err_state_d = ERR_SECOND;
            end
            ERR_SECOND: begin
                err_resp    = 2'b01;
                err_state_d = (accept && ahb.HWRITE) ? ERR_FIRST : ERR_IDLE;
            end
            default: err_state_d = ERR_IDLE;
        endcase
    end
`else
    assign wr_accept = accept & ahb.HWRITE;
    assign err_ready = 1'b1;
    assign err_resp  = 2'b00;
`endif

    assign stall         = wr_dphase_q & buf_valid_q & rd_req;
    assign hready_out    = err_ready & ~stall;
    assign buf_load      = wr_dphase_q & hready_out;
    assign drain         = buf_valid_q & ~rd_accept;
    assign fwd_hit       = rd_dphase_q & buf_valid_q & (buf_addr_q == addr_q);
    assign ahb.HREADYOUT = hready_out;
    assign ahb.HRESP     = err_resp;
    assign ahb.HRDATA    = rdata;

    // Byte-lane strobe for the transfer in address phase.
    always_comb begin
        strb = 4'b1111;
        case (ahb.HSIZE[1:0])
            2'b00:   strb = 4'b0001 << ahb.HADDR[1:0];
            2'b01:   strb = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // Next-state for the address-phase capture and the write buffer.
    always_comb begin
        rd_dphase_d = rd_dphase_q;
        wr_dphase_d = wr_dphase_q;
        addr_d      = addr_q;
        strb_d      = strb_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_strb_d  = buf_strb_q;
        buf_data_d  = buf_data_q;
        if (ahb.HREADY) begin
            rd_dphase_d = rd_accept;
            wr_dphase_d = wr_accept;
            if (accept) begin
                addr_d = haddr_word;
                strb_d = strb;
            end
        end
        // A reload at the same edge as a drain keeps the buffer full.
        if (buf_load) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = addr_q;
            buf_strb_d  = strb_q;
            buf_data_d  = ahb.HWDATA;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending buffered write.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_dphase_q <= 1'b0;
            wr_dphase_q <= 1'b0;
            addr_q      <= '0;
            strb_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_strb_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            rd_dphase_q <= rd_dphase_d;
            wr_dphase_q <= wr_dphase_d;
            addr_q      <= addr_d;
            strb_q      <= strb_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_strb_q  <= buf_strb_d;
            buf_data_q  <= buf_data_d;
        end
    end

    // RAM port: drain the buffer when no read owns the port, else present the read address.
    always_comb begin
        BRAM_WDATA = buf_data_q;
        if (drain) begin
            BRAM_ADDR = buf_addr_q;
            BRAM_WE   = buf_strb_q;
        end else begin
            BRAM_ADDR = haddr_word;
            BRAM_WE   = 4'b0000;
        end
    end

    // Read data with per-lane forwarding from a matching buffered write.
    always_comb begin
        rdata = BRAM_RDATA;
        if (fwd_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_strb_q[i]) rdata[8*i +: 8] = buf_data_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahblite_block_ram.sv
// Bench for ahblite_block_ram: a behavioural word memory predicts every read,
// a RAM model behind the port shows what actually lands in the block RAM.
module tb_ahblite_block_ram;
    localparam int AW     = 13;
    localparam int NWORDS = 64;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [AW-1:0] BRAM_ADDR;
    logic [31:0]   BRAM_RDATA;
    logic [31:0]   BRAM_WDATA;
    logic [3:0]    BRAM_WE;

    ahblite_block_ram_if ahb_if ();
    assign ahb_if.HREADY = ahb_if.HREADYOUT;

    ahblite_block_ram #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .ahb        (ahb_if),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_RDATA (BRAM_RDATA),
        .BRAM_WDATA (BRAM_WDATA),
        .BRAM_WE    (BRAM_WE)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] bram    [0:NWORDS-1];
    logic [31:0] exp_mem [0:NWORDS-1];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_addr;
    logic [31:0] poke_data;

    always @(posedge HCLK) begin
        if (poke_en) bram[poke_addr] <= poke_data;
        for (int n = 0; n < 4; n++)
            if (BRAM_WE[n]) bram[BRAM_ADDR[5:0]][8*n +: 8] <= BRAM_WDATA[8*n +: 8];
        BRAM_RDATA <= bram[BRAM_ADDR[5:0]];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   data;
    } we_rec_t;
    we_rec_t we_log[$];

    always @(negedge HCLK)
        if (!HRESET && BRAM_WE != 4'b0000) we_log.push_back({BRAM_ADDR, BRAM_WE, BRAM_WDATA});

    typedef struct {
        bit          idle;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;
    op_t         ops[$];
    logic [31:0] res_rdata[];
    logic [31:0] res_exp[];
    int          res_stall[];
    logic [1:0]  res_resp[];
    logic [1:0]  res_stall_resp[];

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        ahb_if.HSEL   = 1'b0;
        ahb_if.HTRANS = 2'b00;
        ahb_if.HWRITE = 1'b0;
        ahb_if.HADDR  = 32'h0;
        ahb_if.HSIZE  = 3'd2;
        ahb_if.HPROT  = 4'h0;
        ahb_if.HWDATA = 32'h0;
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        poke_addr = w[5:0];
        poke_data = d;
        poke_en   = 1'b1;
        tick();
        poke_en    = 1'b0;
        exp_mem[w] = d;
    endtask

    task automatic add_op(input bit idle, input bit wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d);
        op_t o;
        o.idle = idle; o.wr = wr; o.addr = a; o.size = sz; o.wdata = d;
        ops.push_back(o);
    endtask

    // Bytes covered by an aligned transfer of 2^sz bytes, each in its own lane.
    function automatic void ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int nb   = 1 << sz;
        int base = int'(a) & ~(nb - 1);
        for (int b = 0; b < nb; b++) begin
            int ba   = base + b;
            int lane = ba % 4;
            exp_mem[ba / 4][8*lane +: 8] = d[8*lane +: 8];
        end
    endfunction

    // Plays ops as a pipelined AHB master; records per-op results, no checking.
    task automatic run_seq();
        int n   = ops.size();
        int ai  = 0;
        int di  = -1;
        int cyc = 0;
        res_rdata      = new[n];
        res_exp        = new[n];
        res_stall      = new[n];
        res_resp       = new[n];
        res_stall_resp = new[n];
        for (int i = 0; i < n; i++) begin
            res_stall[i] = 0; res_resp[i] = 2'b00; res_stall_resp[i] = 2'b00;
            res_rdata[i] = 32'h0; res_exp[i] = 32'h0;
        end
        while ((ai < n || di >= 0) && cyc < 4000) begin
            if (ai < n && !ops[ai].idle) begin
                ahb_if.HSEL   = 1'b1;
                ahb_if.HTRANS = 2'b10;
                ahb_if.HWRITE = ops[ai].wr;
                ahb_if.HADDR  = ops[ai].addr;
                ahb_if.HSIZE  = ops[ai].size;
            end else begin
                ahb_if.HSEL   = 1'b0;
                ahb_if.HTRANS = 2'b00;
                ahb_if.HWRITE = 1'b0;
            end
            ahb_if.HWDATA = (di >= 0 && ops[di].wr) ? ops[di].wdata : 32'h0;
            @(negedge HCLK);
            if (ahb_if.HREADYOUT === 1'b1) begin
                if (di >= 0) begin
                    res_resp[di] = ahb_if.HRESP;
                    if (ops[di].wr) begin
`ifndef AHB_BRAM_RO_ERR_EN
                        ref_write(ops[di].addr, ops[di].size, ops[di].wdata);
`endif
                    end else begin
                        res_rdata[di] = ahb_if.HRDATA;
                        res_exp[di]   = exp_mem[ops[di].addr[7:2]];
                    end
                end
                di = (ai < n && !ops[ai].idle) ? ai : -1;
                if (ai < n) ai++;
            end else if (di >= 0) begin
                res_stall[di]++;
                res_stall_resp[di] = ahb_if.HRESP;
            end
            tick();
            cyc++;
        end
        idle_bus();
        if (cyc >= 4000) begin
            checks++; errors++;
            $display("FAIL run_seq_timeout: sequence of %0d ops still pending after %0d cycles", n, cyc);
        end
    endtask

    task automatic test_reset();
        if (ahb_if.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", ahb_if.HREADYOUT); end
        checks++;
        if (ahb_if.HRESP !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b want 00", ahb_if.HRESP); end
        checks++;
        if (BRAM_WE !== 4'b0000) begin errors++; $display("FAIL reset_bram_we: got %b want 0000", BRAM_WE); end
        checks++;
        HRESET = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_read_only_memory();
        ops.delete();
        add_op(0, 0, 32'h14, 3'd2, 0);
        add_op(0, 0, 32'h18, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        for (int i = 0; i < 2; i++) begin
            if (res_rdata[i] !== res_exp[i]) begin errors++; $display("FAIL plain_read[%0d]: got %h want %h", i, res_rdata[i], res_exp[i]); end
            checks++;
            if (res_stall[i] !== 0) begin errors++; $display("FAIL plain_read_wait[%0d]: got %0d want 0", i, res_stall[i]); end
            checks++;
        end
    endtask

`ifndef AHB_BRAM_RO_ERR_EN
    task automatic test_word_write();
        we_log.delete();
        ops.delete();
        add_op(0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
        add_op(1, 0, 0, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        if (we_log.size() !== 1) begin errors++; $display("FAIL word_we_cycles: got %0d want 1", we_log.size()); end
        checks++;
        if (we_log.size() > 0) begin
            if (we_log[0].we !== 4'b1111 || we_log[0].addr !== 13'd4 || we_log[0].data !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL word_drain: got we=%b addr=%0d data=%h want we=1111 addr=4 data=deadbeef",
                         we_log[0].we, we_log[0].addr, we_log[0].data);
            end
            checks++;
        end
        if (res_resp[0] !== 2'b00 || res_stall[0] !== 0) begin
            errors++; $display("FAIL word_resp: got resp=%b waits=%0d want resp=00 waits=0", res_resp[0], res_stall[0]);
        end
        checks++;
        ops.delete();
        add_op(0, 0, 32'h10, 3'd2, 0);
        run_seq();
        if (res_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_readback: got %h want deadbeef", res_rdata[0]); end
        checks++;
    endtask

    task automatic test_fwd_byte();
        poke(8, 32'h11223344);
        ops.delete();
        add_op(0, 1, 32'h21, 3'd0, 32'h0000AA00);
        add_op(0, 0, 32'h20, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        if (res_stall[0] !== 0 || res_stall[1] !== 0) begin
            errors++; $display("FAIL fwd_byte_wait: got %0d/%0d want 0/0", res_stall[0], res_stall[1]);
        end
        checks++;
        if (res_rdata[1] !== 32'h1122AA44) begin errors++; $display("FAIL fwd_byte_data: got %h want 1122aa44", res_rdata[1]); end
        checks++;
        if (bram[8] !== exp_mem[8]) begin errors++; $display("FAIL fwd_byte_landed: got %h want %h", bram[8], exp_mem[8]); end
        checks++;
    endtask

    task automatic test_fwd_half();
        we_log.delete();
        ops.delete();
        add_op(0, 1, 32'h42, 3'd1, 32'hBEEF0000);
        add_op(0, 0, 32'h40, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        if (we_log.size() < 1 || we_log[0].we !== 4'b1100) begin
            errors++; $display("FAIL half_strobe: got %b want 1100", (we_log.size() > 0) ? we_log[0].we : 4'bxxxx);
        end
        checks++;
        if (res_rdata[1] !== res_exp[1] || res_rdata[1][31:16] !== 16'hBEEF) begin
            errors++; $display("FAIL half_fwd_data: got %h want %h", res_rdata[1], res_exp[1]);
        end
        checks++;
    endtask

    task automatic test_hazard();
        ops.delete();
        add_op(0, 1, 32'h00, 3'd2, $urandom);
        add_op(0, 1, 32'h04, 3'd2, $urandom);
        add_op(0, 0, 32'h08, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        if (res_stall[0] !== 0 || res_stall[1] !== 1 || res_stall[2] !== 0) begin
            errors++; $display("FAIL hazard_waits: got %0d/%0d/%0d want 0/1/0", res_stall[0], res_stall[1], res_stall[2]);
        end
        checks++;
        if (res_rdata[2] !== res_exp[2]) begin errors++; $display("FAIL hazard_read: got %h want %h", res_rdata[2], res_exp[2]); end
        checks++;
        if (bram[0] !== exp_mem[0] || bram[1] !== exp_mem[1]) begin
            errors++; $display("FAIL hazard_landed: got %h %h want %h %h", bram[0], bram[1], exp_mem[0], exp_mem[1]);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int waits = 0;
        we_log.delete();
        ops.delete();
        for (int i = 0; i < 3; i++) add_op(0, 1, 32'h50 + 4*i, 3'd2, $urandom);
        for (int i = 0; i < 3; i++) add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        for (int i = 0; i < 3; i++) waits += res_stall[i];
        if (waits !== 0) begin errors++; $display("FAIL b2b_waits: got %0d want 0", waits); end
        checks++;
        if (we_log.size() !== 3) begin errors++; $display("FAIL b2b_we_cycles: got %0d want 3", we_log.size()); end
        checks++;
        for (int i = 20; i < 23; i++) begin
            if (bram[i] !== exp_mem[i]) begin errors++; $display("FAIL b2b_landed[%0d]: got %h want %h", i, bram[i], exp_mem[i]); end
            checks++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] old = exp_mem[12];
        ahb_if.HSEL = 1'b1; ahb_if.HTRANS = 2'b10; ahb_if.HWRITE = 1'b1;
        ahb_if.HSIZE = 3'd2; ahb_if.HADDR = 32'h30;
        tick();
        ahb_if.HSEL = 1'b0; ahb_if.HTRANS = 2'b00; ahb_if.HWRITE = 1'b0;
        ahb_if.HWDATA = 32'hCAFEF00D;
        tick();
        if (BRAM_WE !== 4'b1111) begin errors++; $display("FAIL midrst_buffer_full: got we=%b want 1111", BRAM_WE); end
        checks++;
        HRESET = 1'b1;
        #1;
        if (ahb_if.HREADYOUT !== 1'b1 || ahb_if.HRESP !== 2'b00 || BRAM_WE !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outputs: got ready=%b resp=%b we=%b want 1 00 0000", ahb_if.HREADYOUT, ahb_if.HRESP, BRAM_WE);
        end
        checks++;
        tick();
        tick();
        HRESET = 1'b0;
        idle_bus();
        tick();
        ops.delete();
        add_op(0, 0, 32'h30, 3'd2, 0);
        run_seq();
        if (res_rdata[0] !== old) begin errors++; $display("FAIL midrst_readback: got %h want %h", res_rdata[0], old); end
        checks++;
        if (bram[12] !== old) begin errors++; $display("FAIL midrst_bram: got %h want %h", bram[12], old); end
        checks++;
    endtask

    task automatic test_random();
        ops.delete();
        for (int i = 0; i < 300; i++) begin
            int r  = $urandom_range(0, 99);
            int w  = $urandom_range(0, 15);
            int sz = $urandom_range(0, 2);
            int off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
            if (r < 15)      add_op(1, 0, 0, 3'd2, 0);
            else if (r < 55) add_op(0, 1, 32'(4*w + off), 3'(sz), $urandom);
            else             add_op(0, 0, 32'(4*w), 3'd2, 0);
        end
        for (int i = 0; i < 3; i++) add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        for (int i = 0; i < ops.size(); i++) begin
            if (!ops[i].idle && !ops[i].wr) begin
                if (res_rdata[i] !== res_exp[i]) begin
                    errors++; $display("FAIL rand_read[%0d] @%h: got %h want %h", i, ops[i].addr, res_rdata[i], res_exp[i]);
                end
                checks++;
            end
            if (!ops[i].idle) begin
                if (res_stall[i] > 1) begin errors++; $display("FAIL rand_waits[%0d]: got %0d want <=1", i, res_stall[i]); end
                checks++;
            end
        end
        for (int w = 0; w < 16; w++) begin
            if (bram[w] !== exp_mem[w]) begin errors++; $display("FAIL rand_landed[%0d]: got %h want %h", w, bram[w], exp_mem[w]); end
            checks++;
        end
    endtask
`else
    task automatic test_ro_err();
        we_log.delete();
        ops.delete();
        add_op(0, 1, 32'h00, 3'd2, 32'h12345678);
        add_op(0, 0, 32'h00, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        add_op(1, 0, 0, 3'd2, 0);
        run_seq();
        if (res_stall[0] !== 1 || res_stall_resp[0] !== 2'b01) begin
            errors++; $display("FAIL ro_first_cycle: got waits=%0d resp=%b want 1 01", res_stall[0], res_stall_resp[0]);
        end
        checks++;
        if (res_resp[0] !== 2'b01) begin errors++; $display("FAIL ro_second_cycle: got resp=%b want 01", res_resp[0]); end
        checks++;
        if (res_resp[1] !== 2'b00 || res_stall[1] !== 0) begin
            errors++; $display("FAIL ro_next_read: got resp=%b waits=%0d want 00 0", res_resp[1], res_stall[1]);
        end
        checks++;
        if (res_rdata[1] !== res_exp[1]) begin errors++; $display("FAIL ro_read_data: got %h want %h", res_rdata[1], res_exp[1]); end
        checks++;
        if (we_log.size() !== 0) begin errors++; $display("FAIL ro_bram_we: got %0d write cycles want 0", we_log.size()); end
        checks++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        idle_bus();
        tick();
        for (int w = 0; w < NWORDS; w++) poke(w, $urandom);
        test_reset();
        test_read_only_memory();
`ifndef AHB_BRAM_RO_ERR_EN
        test_word_write();
        test_fwd_byte();
        test_fwd_half();
        test_hazard();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
`else
        test_ro_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
